seq_mult: RTL
=============

Name: seq_mult

Overview:
- Parametrised sequential shift-add multiplier: unsigned WIDTH x WIDTH -> 2*WIDTH product, one iteration per clock.
- Integrates the product shift/load register with its own controller FSM and a start/busy/done handshake, so the datapath needs no external sequencing.
- Sits beside the existing 4-bit product register; WIDTH=4 is the drop-in configuration.

Parameters:
- WIDTH, 4, operand width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- clr  input  1  reset, synchronous, active-high; clears all state and outputs
- start  input  1  request; sampled on the clock edge
- a  input  WIDTH  multiplicand; captured when start is accepted
- b  input  WIDTH  multiplier; captured when start is accepted
- busy  output  1  high while iterating (RUN state)
- done  output  1  one-cycle pulse: result valid and just updated
- product  output  2*WIDTH  last completed result; held until the next completion

Behaviour:
- Reset (clr=1 at an edge): state=IDLE, busy=0, done=0, product=0, internal accumulator/count=0. clr overrides start and takes effect mid-operation; the run in progress is discarded with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE: start=1 -> RUN. On that edge, M<=a, acc<={WIDTH'b0, b}, carry<=0, cnt<=0.
- RUN, per edge: if acc[0]=1, {c, upper} = upper + M (WIDTH+1-bit add); else c=0. Then acc <= {c, upper, lower} >> 1, and cnt++.
- RUN exit: the edge with cnt==WIDTH-1 performs the final iteration, goes to DONE, and loads product with the final acc.
- DONE: done=1 for exactly this cycle and busy=0. Next edge: start=1 -> accepted as in IDLE (back-to-back, RUN); else -> IDLE.
- busy=1 exactly in RUN. done=1 exactly in DONE.
- Latency: start accepted at edge 0. Iterations occur at edges 1..WIDTH. done is high from edge WIDTH to edge WIDTH+1. Throughput is one result per WIDTH+1 cycles.
- start while in RUN: ignored. a and b may change freely after acceptance.
- product changes only on the edge entering DONE, or on clr. It is otherwise stable, including during RUN.
- The add carry is never lost: the accumulator is 2*WIDTH+1 bits wide during the iteration.

Optional Feature:
- Macro: SEQ_MULT_SIGNED_EN.
- Defined: add input `sgn` (1 bit), sampled with start.
  - When sgn=1, a and b are two's complement. On acceptance, load |a| and |b| (a value of -2^(WIDTH-1) maps to unsigned 2^(WIDTH-1)) and register neg = a[MSB]^b[MSB].
  - On the edge entering DONE, product <= neg ? -acc : acc. There is no added latency.
  - When sgn=0, behaviour is identical to the unsigned case.
- Undefined: no sgn port; unsigned only; no negation logic.

Decomposition:
- Package seq_mult_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the localparam CNT_W = $clog2(WIDTH);
  - a function computing the result width, 2*WIDTH.
- Natural sub-module seq_mult_acc: the accumulator register with clear/load/add-shift controls (the generalised product register), driven by the FSM in seq_mult.

Test Plan (WIDTH=4 unless noted):
- Basic: a=7, b=5, start one cycle after clr release. Required: busy for 4 cycles; done pulse at edge 4 after acceptance; product=8'h23, held afterwards.
- Corner operands: 15x15 -> 8'hE1 (carry path exercised); 0x9 -> 8'h00; 9x1 -> 8'h09.
- Handshake: start held high continuously with a=3, b=3 then a=2, b=6. Required: start ignored during RUN; second run accepted in the DONE cycle; products 8'h09 then 8'h0C; done pulses 5 cycles apart.
- Reset mid-run: clr at iteration 2 of a 7x5 run. Required: next cycle busy=0, done=0, product=0, no done pulse; a following 6x6 run gives 8'h24.
- Width sweep: WIDTH=8, 255x255. Required: product 16'hFE01 with done at edge 8.
- SEQ_MULT_SIGNED_EN, sgn=1:
  - -8x-8 -> 8'h40
  - -3x5 -> 8'hF1
  - 7x-1 -> 8'hF9
  - sgn=0 with 4'hF x 4'hF -> 8'hE1

Source files
------------

// File: rtl/seq_mult_pkg.sv
// Shared state encoding and width helpers for the seq_mult shift-add multiplier.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Iteration counter width: must hold 0..width-1.
    function automatic int unsigned cnt_w(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

    function automatic int unsigned prod_w(input int unsigned width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/seq_mult_acc.sv
// Product/accumulator register: load {0, b}, or one add-shift step against multiplicand m_i.
module seq_mult_acc
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      clr_i,
    input  logic                      load_i,
    input  logic                      step_i,
    input  logic [WIDTH-1:0]          b_i,
    input  logic [WIDTH-1:0]          m_i,
    output logic [prod_w(WIDTH)-1:0]  acc_nxt_c
);

    localparam int unsigned PW = prod_w(WIDTH);

    logic [PW-1:0] acc_q;
    logic [PW-1:0] acc_d;
    logic [WIDTH:0] sum_c;

    // The W+1-bit sum keeps the carry; it drops back into the MSB on the shift.
    always_comb begin
        sum_c = {1'b0, acc_q[PW-1:WIDTH]};
        if (acc_q[0]) begin
            sum_c = sum_c + {1'b0, m_i};
        end
        acc_nxt_c = {sum_c, acc_q[WIDTH-1:1]};
    end

    always_comb begin
        acc_d = acc_q;
        if (load_i) begin
            acc_d = {{WIDTH{1'b0}}, b_i};
        end else if (step_i) begin
            acc_d = acc_nxt_c;
        end
    end

    always_ff @(posedge clk) begin
        if (clr_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/seq_mult.sv
// Sequential WIDTH x WIDTH shift-add multiplier with start/busy/done handshake.
// Define SEQ_MULT_SIGNED_EN to add the sgn input for two's complement operands.
module seq_mult
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic                      start,
`ifdef SEQ_MULT_SIGNED_EN
    input  logic                      sgn,
`endif
    input  logic [WIDTH-1:0]          a,
    input  logic [WIDTH-1:0]          b,
    output logic                      busy,
    output logic                      done,
    output logic [prod_w(WIDTH)-1:0]  product
);

    localparam int unsigned PW = prod_w(WIDTH);
    localparam int unsigned CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e         state_q;
    logic           busy_q;
    logic           done_q;
    logic [PW-1:0]  product_q;
    logic [CW-1:0]  cnt_q;
    logic [WIDTH-1:0] m_q;

    logic             load_c;
    logic             step_c;
    logic [WIDTH-1:0] a_mag_c;
    logic [WIDTH-1:0] b_mag_c;
    logic [PW-1:0]    acc_nxt_c;
    logic [PW-1:0]    result_c;

    assign load_c = start && (state_q != RUN);
    assign step_c = (state_q == RUN);

`ifdef SEQ_MULT_SIGNED_EN
    logic neg_q;
    logic neg_c;

    // Magnitudes: the most negative value wraps to 2^(W-1), which is correct unsigned.
    assign a_mag_c  = (sgn && a[WIDTH-1]) ? WIDTH'(-a) : a;
    assign b_mag_c  = (sgn && b[WIDTH-1]) ? WIDTH'(-b) : b;
    assign neg_c    = sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
    assign result_c = neg_q ? PW'(-acc_nxt_c) : acc_nxt_c;

    always_ff @(posedge clk) begin
        if (clr) begin
            neg_q <= 1'b0;
        end else if (load_c) begin
            neg_q <= neg_c;
        end
    end
`else
    assign a_mag_c  = a;
    assign b_mag_c  = b;
    assign result_c = acc_nxt_c;
`endif

    seq_mult_acc #(
        .WIDTH (WIDTH)
    ) u_acc (
        .clk       (clk),
        .clr_i     (clr),
        .load_i    (load_c),
        .step_i    (step_c),
        .b_i       (b_mag_c),
        .m_i       (m_q),
        .acc_nxt_c (acc_nxt_c)
    );

    // Controller: DONE accepts a new start exactly like IDLE for back-to-back runs.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
            cnt_q     <= '0;
            m_q       <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    busy_q <= 1'b0;
                    if (start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        m_q     <= a_mag_c;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_q   <= DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        product_q <= result_c;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule
